// File: rtl/spacy_pkg.sv
// Shared SpacyBird definitions: FSM state encodings and counter sizing helper.
package spacy_pkg;

    localparam logic [1:0] ST_IDLE = 2'd0;
    localparam logic [1:0] ST_HIGH = 2'd1;
    localparam logic [1:0] ST_GAP  = 2'd2;

    // Bits needed to hold maxVal; never less than one.
    function automatic int unsigned cntWidth(input int unsigned maxVal);
        int unsigned w;
        w = 1;
        for (int unsigned i = 1; i < 32; i++) begin
            if ((maxVal >> i) != 0) w = i + 1;
        end
        return w;
    endfunction

endpackage

// File: rtl/load_down_counter.sv
// Loadable down counter that holds at zero; load has priority over decrement.
module load_down_counter #(
    parameter int unsigned N = 4
) (
    input  logic         iClk,
    input  logic         iRst,
    input  logic         iLoad,
    input  logic [N-1:0] iVal,
    input  logic         iEn,
    output logic [N-1:0] oCnt,
    output logic         oZero
);

    always_ff @(posedge iClk or negedge iRst) begin
        if (!iRst) begin
            oCnt <= '0;
        end else if (iLoad) begin
            oCnt <= iVal;
        end else if (iEn && (oCnt != '0)) begin
            oCnt <= oCnt - 1'b1;
        end
    end

    assign oZero = (oCnt == '0);

endmodule

// File: rtl/pulse_stretcher.sv
// Stretches single-cycle events into WIDTH-cycle level pulses separated by at
// least GAP low cycles; overlapping events are queued or retrigger the pulse.
module pulse_stretcher
    import spacy_pkg::*;
#(
    parameter int unsigned WIDTH    = 4,
    parameter int unsigned GAP      = 2,
    parameter int unsigned RETRIG   = 0,
    parameter int unsigned PEND_MAX = 3,
    parameter int unsigned PEND_W   = 2
) (
    input  logic              iClk,
    input  logic              iRst,
    input  logic              iSig,
    output logic              oSig,
    output logic              oBusy,
    output logic              oDone,
    output logic              oDrop,
    output logic [PEND_W-1:0] oPending
);

    localparam int unsigned CW = cntWidth(WIDTH - 1);
    localparam int unsigned GW = cntWidth(GAP - 1);
    localparam logic [CW-1:0]     W_LOAD = CW'(WIDTH - 1);
    localparam logic [GW-1:0]     G_LOAD = GW'(GAP - 1);
    localparam logic [PEND_W-1:0] P_MAX  = PEND_W'(PEND_MAX);

    logic [1:0]        state, stateNext;
    logic [PEND_W-1:0] pendNext;
    logic              wLoad, wEn, wZero, gLoad, gEn, gZero;
    logic [CW-1:0]     wCnt;
    logic [GW-1:0]     gCnt;
    logic              inc, incOk, dec, doneNext, dropNext;
    logic              unusedCnt;

    load_down_counter #(.N(CW)) uWidthCnt (
        .iClk(iClk), .iRst(iRst), .iLoad(wLoad), .iVal(W_LOAD),
        .iEn(wEn), .oCnt(wCnt), .oZero(wZero)
    );

    load_down_counter #(.N(GW)) uGapCnt (
        .iClk(iClk), .iRst(iRst), .iLoad(gLoad), .iVal(G_LOAD),
        .iEn(gEn), .oCnt(gCnt), .oZero(gZero)
    );

    assign unusedCnt = ^{wCnt, gCnt};

    always_comb begin
        stateNext = state;
        wLoad     = 1'b0;
        wEn       = 1'b0;
        gLoad     = 1'b0;
        gEn       = 1'b0;
        doneNext  = 1'b0;
        dec       = 1'b0;
        inc       = iSig && (((state == ST_HIGH) && (RETRIG == 0)) || (state == ST_GAP));
        dropNext  = inc && (oPending == P_MAX);
        incOk     = inc && !dropNext;
        case (state)
            ST_IDLE: begin
                if (iSig) begin
                    stateNext = ST_HIGH;
                    wLoad     = 1'b1;
                end
            end
            ST_HIGH: begin
                if (iSig && (RETRIG != 0)) begin
                    wLoad = 1'b1;
                end else if (wZero) begin
                    stateNext = ST_GAP;
                    gLoad     = 1'b1;
                    doneNext  = 1'b1;
                end else begin
                    wEn = 1'b1;
                end
            end
            ST_GAP: begin
                // An event in the last gap cycle counts before the queue is tested.
                if (!gZero) begin
                    gEn = 1'b1;
                end else if ((oPending != '0) || incOk) begin
                    dec       = 1'b1;
                    stateNext = ST_HIGH;
                    wLoad     = 1'b1;
                end else begin
                    stateNext = ST_IDLE;
                end
            end
            default: stateNext = ST_IDLE;
        endcase
        pendNext = oPending + PEND_W'(incOk) - PEND_W'(dec);
    end

    always_ff @(posedge iClk or negedge iRst) begin
        if (!iRst) begin
            state    <= ST_IDLE;
            oPending <= '0;
            oSig     <= 1'b0;
            oBusy    <= 1'b0;
            oDone    <= 1'b0;
            oDrop    <= 1'b0;
        end else begin
            state    <= stateNext;
            oPending <= pendNext;
            oSig     <= (stateNext == ST_HIGH);
            oBusy    <= (stateNext != ST_IDLE);
            oDone    <= doneNext;
            oDrop    <= dropNext;
        end
    end

endmodule

// File: tb/tb_pulse_stretcher.sv
// Directed bench for pulse_stretcher: per-cycle expected waveforms are queued
// as each input is driven and compared once the DUT has clocked it.
module tb_pulse_stretcher;

    logic       clk = 1'b0;
    logic       rstN;
    logic       sig0, sig1;
    logic       s0Sig, s0Busy, s0Done, s0Drop;
    logic       s1Sig, s1Busy, s1Done, s1Drop;
    logic [1:0] s0Pend, s1Pend;

    typedef struct {
        logic [3:0] sig;
        logic [3:0] busy;
        logic [3:0] done;
        logic [3:0] drop;
        logic [3:0] pend;
    } expT;

    expT sb[$];
    int  passCount = 0;
    int  checkCount = 0;
    int  failCount = 0;

    always #5 clk = ~clk;

    pulse_stretcher #(.WIDTH(4), .GAP(2), .RETRIG(0), .PEND_MAX(3), .PEND_W(2)) dutQueue (
        .iClk(clk), .iRst(rstN), .iSig(sig0), .oSig(s0Sig), .oBusy(s0Busy),
        .oDone(s0Done), .oDrop(s0Drop), .oPending(s0Pend)
    );

    pulse_stretcher #(.WIDTH(4), .GAP(2), .RETRIG(1), .PEND_MAX(3), .PEND_W(2)) dutRetrig (
        .iClk(clk), .iRst(rstN), .iSig(sig1), .oSig(s1Sig), .oBusy(s1Busy),
        .oDone(s1Done), .oDrop(s1Drop), .oPending(s1Pend)
    );

    task automatic check(input string tag, input logic [3:0] obs, input logic [3:0] exp);
        checkCount++;
        assert (obs === exp) passCount++;
        else begin
            failCount++;
            $error("FAIL %s: observed %0d expected %0d (fail #%0d)", tag, obs, exp, failCount);
        end
    endtask

    function automatic logic [3:0] digit(input string s, input int idx);
        return 4'(s[idx] - 8'h30);
    endfunction

    // Strings are indexed by cycle: ev[c] is sampled at edge c, the others give
    // the outputs seen in cycle c (after edge c-1).
    task automatic runCase(input string name, input bit sel, input string ev,
                           input string sigS, input string busyS, input string doneS,
                           input string dropS, input string pendS);
        expT e;
        for (int c = 0; c < ev.len() - 1; c++) begin
            if (sel) sig1 = (ev[c] == 8'h31);
            else     sig0 = (ev[c] == 8'h31);
            e.sig  = digit(sigS, c + 1);
            e.busy = digit(busyS, c + 1);
            e.done = digit(doneS, c + 1);
            e.drop = digit(dropS, c + 1);
            e.pend = digit(pendS, c + 1);
            sb.push_back(e);
            @(posedge clk);
            #1;
            e = sb.pop_front();
            check($sformatf("%s c%0d oSig", name, c + 1), {3'b0, sel ? s1Sig : s0Sig}, e.sig);
            check($sformatf("%s c%0d oBusy", name, c + 1), {3'b0, sel ? s1Busy : s0Busy}, e.busy);
            check($sformatf("%s c%0d oDone", name, c + 1), {3'b0, sel ? s1Done : s0Done}, e.done);
            check($sformatf("%s c%0d oDrop", name, c + 1), {3'b0, sel ? s1Drop : s0Drop}, e.drop);
            check($sformatf("%s c%0d oPending", name, c + 1), {2'b0, sel ? s1Pend : s0Pend}, e.pend);
        end
        sig0 = 1'b0;
        sig1 = 1'b0;
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: simulation exceeded time limit");
        $fatal(1, "watchdog expired");
    end

    initial begin
        rstN = 1'b0;
        sig0 = 1'b0;
        sig1 = 1'b0;
        #3;
        check("reset oSig", {3'b0, s0Sig}, 4'd0);
        check("reset oBusy", {3'b0, s0Busy}, 4'd0);
        check("reset oDone", {3'b0, s0Done}, 4'd0);
        check("reset oDrop", {3'b0, s0Drop}, 4'd0);
        check("reset oPending", {2'b0, s0Pend}, 4'd0);
        check("reset retrig oSig", {3'b0, s1Sig}, 4'd0);
        check("reset retrig oBusy", {3'b0, s1Busy}, 4'd0);
        @(negedge clk);
        rstN = 1'b1;
        @(posedge clk);
        #1;

        runCase("single", 1'b0, "100000000",
                "011110000", "011111100", "000001000", "000000000", "000000000");

        runCase("queue2", 1'b0, "10100000000000",
                "01111001111000", "01111111111110", "00000100000100",
                "00000000000000", "00011110000000");

        runCase("retrig", 1'b1, "10010000000",
                "01111111000", "01111111110", "00000000100",
                "00000000000", "00000000000");

        runCase("saturate", 1'b0, "11111000000000000000000000",
                "01111001111001111001111000", "01111111111111111111111110",
                "00000100000100000100000100", "00000100000000000000000000",
                "00123332222221111110000000");

        runCase("lastgap", 1'b0, "10000010000000",
                "01111001111000", "01111111111110", "00000100000100",
                "00000000000000", "00000000000000");

        // Reset mid-pulse with one event queued, then a fresh event afterwards.
        sig0 = 1'b1;
        @(posedge clk);
        #1;
        @(posedge clk);
        #1;
        sig0 = 1'b0;
        check("prerst oSig", {3'b0, s0Sig}, 4'd1);
        check("prerst oPending", {2'b0, s0Pend}, 4'd1);
        @(posedge clk);
        #4;
        rstN = 1'b0;
        #1;
        check("asyncrst oSig", {3'b0, s0Sig}, 4'd0);
        check("asyncrst oBusy", {3'b0, s0Busy}, 4'd0);
        check("asyncrst oPending", {2'b0, s0Pend}, 4'd0);
        #10;
        rstN = 1'b1;
        @(posedge clk);
        #1;
        check("postrst oBusy", {3'b0, s0Busy}, 4'd0);
        runCase("afterrst", 1'b0, "10000000",
                "01111000", "01111110", "00000100", "00000000", "00000000");

        $display("%0d/%0d checks passed", passCount, checkCount);
        $finish;
    end

endmodule
